// File: rtl/mem_stage_dmem.sv
// MEM pipeline stage: data memory with a fixed multi-cycle access latency.
// Freezes upstream stages during an access and bubbles the MEM/WB controls.
module mem_stage_dmem #(
    parameter int          DEPTH     = 64,
    parameter int          LAT       = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_EXE,
    input  logic        MEM_R_EN_EXE,
    input  logic        MEM_W_EN_EXE,
    input  logic [4:0]  DST_EXE,
    input  logic [31:0] ALU_result_EXE,
    input  logic [31:0] Val_Rm_EXE,
    output logic        WB_EN_MEM,
    output logic        MEM_R_EN_MEM,
    output logic [4:0]  DST_MEM,
    output logic [31:0] ALU_result_MEM,
    output logic [31:0] Mem_data_out,
    output logic        freeze,
    output logic        addr_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        access;
    logic        req;
    logic [31:0] offset;
    logic [29:0] word;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        unused_bits;

    logic [31:0] mem [DEPTH];

    assign req      = MEM_R_EN_EXE | MEM_W_EN_EXE;
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset   = ALU_result_EXE - BASE_ADDR;
    assign word     = offset[31:2];
    assign in_range = (word < DEPTH_W);
    assign idx      = word[AW-1:0];
    assign unused_bits = ^{offset[1:0], word};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = LAT_M1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            Mem_data_out <= 32'd0;
            addr_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (access) begin
                if (!in_range)
                    addr_err <= 1'b1;
                // A combined read/write is treated as a store: load data holds.
                if (MEM_R_EN_EXE && !MEM_W_EN_EXE)
                    Mem_data_out <= in_range ? mem[idx] : 32'd0;
            end
        end
    end

    // Array is intentionally not reset; rst gating aborts a pending store.
    always_ff @(posedge clk) begin
        if (rst && access && MEM_W_EN_EXE && in_range)
            mem[idx] <= Val_Rm_EXE;
    end

    assign freeze         = rst & req & (state != DONE);
    assign WB_EN_MEM      = rst & ~freeze & WB_EN_EXE;
    assign MEM_R_EN_MEM   = rst & ~freeze & MEM_R_EN_EXE;
    assign DST_MEM        = rst ? DST_EXE : 5'd0;
    assign ALU_result_MEM = rst ? ALU_result_EXE : 32'd0;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed testbench for mem_stage_dmem with hand-computed expectations.
module tb_mem_stage_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE;
    logic [4:0]  DST_EXE;
    logic [31:0] ALU_result_EXE, Val_Rm_EXE;
    logic        WB_EN_MEM, MEM_R_EN_MEM;
    logic [4:0]  DST_MEM;
    logic [31:0] ALU_result_MEM, Mem_data_out;
    logic        freeze, addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_dmem dut (
        .clk(clk), .rst(rst),
        .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
        .DST_EXE(DST_EXE), .ALU_result_EXE(ALU_result_EXE), .Val_Rm_EXE(Val_Rm_EXE),
        .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .DST_MEM(DST_MEM),
        .ALU_result_MEM(ALU_result_MEM), .Mem_data_out(Mem_data_out),
        .freeze(freeze), .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [4:0] dst,
                         input logic [31:0] alu, input logic [31:0] val);
        WB_EN_EXE      = wb;
        MEM_R_EN_EXE   = r;
        MEM_W_EN_EXE   = w;
        DST_EXE        = dst;
        ALU_result_EXE = alu;
        Val_Rm_EXE     = val;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents one memory op, expects LAT+1 = 3 freeze cycles then a DONE cycle.
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [31:0] addr, input logic [31:0] val,
                          output logic [31:0] rdata);
        int fc;
        drive(1'b1, r, w, 5'd7, addr, val);
        fc = 0;
        @(negedge clk);
        while (freeze && fc < 20) begin
            if (fc == 0) begin
                chk({tag, "_wb_bubble"}, {31'd0, WB_EN_MEM}, 32'd0);
                chk({tag, "_mr_bubble"}, {31'd0, MEM_R_EN_MEM}, 32'd0);
            end
            fc++;
            @(negedge clk);
        end
        chk({tag, "_freeze_cycles"}, fc, 32'd3);
        chk({tag, "_wb_done"}, {31'd0, WB_EN_MEM}, 32'd1);
        chk({tag, "_mr_done"}, {31'd0, MEM_R_EN_MEM}, {31'd0, r});
        rdata = Mem_data_out;
        step();
    endtask

    logic [31:0] rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with live inputs: forced outputs must read zero.
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_00FF, 32'd0);
        repeat (3) step();
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_wb", {31'd0, WB_EN_MEM}, 32'd0);
        chk("rst_mr", {31'd0, MEM_R_EN_MEM}, 32'd0);
        chk("rst_dst", {27'd0, DST_MEM}, 32'd0);
        chk("rst_alu", ALU_result_MEM, 32'd0);
        chk("rst_mdo", Mem_data_out, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        step();

        // 1: non-memory op passes straight through.
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nm_freeze", {31'd0, freeze}, 32'd0);
            chk("nm_wb", {31'd0, WB_EN_MEM}, 32'd1);
            chk("nm_dst", {27'd0, DST_MEM}, 32'd5);
            chk("nm_alu", ALU_result_MEM, 32'h0000_1234);
            step();
        end

        // 2: store then load at 1028.
        access("st1028", 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, rd);
        access("ld1028", 1'b1, 1'b0, 32'd1028, 32'd0, rd);
        chk("ld1028_data", rd, 32'hDEAD_BEEF);

        // 3: back-to-back loads of 1024 and 1032.
        access("st1024", 1'b0, 1'b1, 32'd1024, 32'h0000_00A0, rd);
        access("st1032", 1'b0, 1'b1, 32'd1032, 32'h0000_00B0, rd);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        access("ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, rd);
        chk("ld1024_data", rd, 32'h0000_00A0);
        access("ld1032", 1'b1, 1'b0, 32'd1032, 32'd0, rd);
        chk("ld1032_data", rd, 32'h0000_00B0);
        chk("err_before_oor", {31'd0, addr_err}, 32'd0);

        // 4: out-of-range above and below the window; sticky error.
        access("ld1280", 1'b1, 1'b0, 32'd1280, 32'd0, rd);
        chk("ld1280_data", rd, 32'd0);
        chk("ld1280_err", {31'd0, addr_err}, 32'd1);
        access("ld1024b", 1'b1, 1'b0, 32'd1024, 32'd0, rd);
        chk("ld1024b_data", rd, 32'h0000_00A0);
        access("ld1020", 1'b1, 1'b0, 32'd1020, 32'd0, rd);
        chk("ld1020_data", rd, 32'd0);
        access("ld1028b", 1'b1, 1'b0, 32'd1028, 32'd0, rd);
        chk("ld1028b_data", rd, 32'hDEAD_BEEF);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);

        // 5: reset on the edge that would perform the store.
        access("st1036", 1'b0, 1'b1, 32'd1036, 32'h0000_0011, rd);
        drive(1'b1, 1'b0, 1'b1, 5'd9, 32'd1036, 32'h0000_0055);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_freeze", {31'd0, freeze}, 32'd0);
        chk("mid_rst_dst", {27'd0, DST_MEM}, 32'd0);
        step();
        chk("post_rst_freeze", {31'd0, freeze}, 32'd0);
        chk("post_rst_wb", {31'd0, WB_EN_MEM}, 32'd0);
        chk("post_rst_alu", ALU_result_MEM, 32'd0);
        chk("post_rst_mdo", Mem_data_out, 32'd0);
        chk("post_rst_err", {31'd0, addr_err}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        step();
        access("ld1036", 1'b1, 1'b0, 32'd1036, 32'd0, rd);
        chk("ld1036_data", rd, 32'h0000_0011);

        // 6: both enables: store wins, load data holds.
        access("rw1040", 1'b1, 1'b1, 32'd1040, 32'h0000_0077, rd);
        chk("rw1040_hold", rd, 32'h0000_0011);
        access("ld1040", 1'b1, 1'b0, 32'd1040, 32'd0, rd);
        chk("ld1040_data", rd, 32'h0000_0077);
        chk("err_clear_kept", {31'd0, addr_err}, 32'd0);

        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
- Pipeline MEM stage: sits between the EXE/MEM register and the MEM/WB register.
- Holds the data memory and models a fixed multi-cycle access latency.
- Asserts freeze to stall all upstream stages during an access.
- Presents WB control, destination, ALU result and load data to the MEM/WB register.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory.
LAT, 2, wait cycles per memory access; legal range 1..15.
BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-low reset.
WB_EN_EXE  in  1  write-back enable from EXE/MEM.
MEM_R_EN_EXE  in  1  load request.
MEM_W_EN_EXE  in  1  store request.
DST_EXE  in  5  destination register.
ALU_result_EXE  in  32  effective byte address, or ALU result.
Val_Rm_EXE  in  32  store data.
WB_EN_MEM  out  1  write-back enable to MEM/WB.
MEM_R_EN_MEM  out  1  load flag to MEM/WB.
DST_MEM  out  5  destination to MEM/WB.
ALU_result_MEM  out  32  ALU result to MEM/WB.
Mem_data_out  out  32  load data, registered.
freeze  out  1  stall for PC, IF/ID, ID/EXE and EXE/MEM.
addr_err  out  1  sticky out-of-range flag.

Behaviour:
- req = MEM_R_EN_EXE | MEM_W_EN_EXE.
- idx = (ALU_result_EXE - BASE_ADDR) >> 2; address bits [1:0] are ignored.
- Address is in range iff 0 <= idx < DEPTH, with the subtraction treated as unsigned 32-bit.
- FSM states: IDLE, WAIT, DONE; down-counter cnt of 4 bits.
  - IDLE: if req, load cnt <= LAT-1 and go to WAIT; otherwise stay in IDLE.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0, perform the access on this edge and go to DONE.
  - DONE: unconditionally go to IDLE.
- Access, performed on the WAIT->DONE edge:
  - Store: mem[idx] <= Val_Rm_EXE.
  - Load: Mem_data_out <= mem[idx].
  - Both enables set: store wins and Mem_data_out is unchanged.
  - Out-of-range: store is dropped, load returns 0, addr_err <= 1.
- freeze = req & (state != DONE), combinational.
  - A request first seen at cycle t holds freeze high for cycles t..t+LAT (LAT+1 cycles).
  - DONE occurs at cycle t+LAT+1 with freeze low, so upstream advances at the end of DONE.
- Output pass-through:
  - DST_MEM = DST_EXE and ALU_result_MEM = ALU_result_EXE, always.
  - While freeze=1, WB_EN_MEM = 0 and MEM_R_EN_MEM = 0, which inserts a bubble into MEM/WB.
  - Otherwise WB_EN_MEM = WB_EN_EXE and MEM_R_EN_MEM = MEM_R_EN_EXE.
- Non-memory instructions in IDLE pass with zero added latency and no freeze.
- Back-to-back accesses: the instruction after DONE is sampled in IDLE. If it is a request, freeze rises in that same cycle, with no gap cycle required.
- Inputs must be stable while freeze=1; this is guaranteed upstream and is not checked.
- Reset (rst=0 at a clock edge):
  - state <= IDLE, cnt <= 0, Mem_data_out <= 0, addr_err <= 0.
  - While rst=0: freeze, WB_EN_MEM, MEM_R_EN_MEM, DST_MEM and ALU_result_MEM are forced to 0.
  - Reset mid-access aborts the access; a store not yet performed is never written.
  - Memory array contents are not cleared by reset.
- addr_err clears only on reset.

Test Plan:
1. Non-memory op: WB_EN_EXE=1, DST=5, ALU_result=0x1234, req=0 -> same cycle WB_EN_MEM=1, DST_MEM=5, ALU_result_MEM=0x1234, freeze=0 in every cycle.
2. Store 0xDEADBEEF to 1028, LAT=2 -> freeze high 3 cycles, WB_EN_MEM=0 throughout. Then a load from 1028 -> freeze high 3 cycles, then DONE cycle with Mem_data_out=0xDEADBEEF, MEM_R_EN_MEM=1, WB_EN_MEM=1.
3. Back-to-back: load 1024 then load 1032 presented the cycle after DONE -> freeze 3 cycles, 1 cycle low, 3 cycles high. Both data values are correct.
4. Out-of-range: load from 1024+4*64=1280, and separately from 1020 -> Mem_data_out=0 and addr_err=1, which stays 1 after later valid accesses until rst=0.
5. Reset mid-access: store 0x55 to 1036, rst=0 while in WAIT -> next cycle freeze=0, all forced outputs 0. A later load of 1036 returns its prior content, not 0x55.
6. Simultaneous R and W enables with data 0x77 to 1040 -> mem[1040] becomes 0x77 and Mem_data_out holds its previous value.
